unified_buffer_arb: RTL and testbench

Successor to the single-command unified buffer. The word storage is shared between a host/FIFO port and a compute port, and a round-robin arbiter allows one memory access per cycle.
- FIFO port: single-section reads and writes; the number of sections is parametrised.
- Compute port: multi-word bursts with auto-incrementing addresses.
- All transfers use valid/ready handshakes, and completion is signalled with pulses.

The block sits between the host FIFOs and the systolic array's compute unit.

---
 rtl/unified_buffer_arb.sv | 200 ++++++++++++++++++++
 tb/tb_unified_buffer_arb.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_buffer_arb.sv
// Word buffer shared by a single-section FIFO port and an auto-incrementing burst compute port.
// One memory access per cycle, round-robin arbitrated. Optional macro: UB_BOUNDS_CHECK_EN.
module unified_buffer_arb #(
    parameter int BUFFER_SIZE        = 1024,
    parameter int BUFFER_WORD_SIZE   = 16,
    parameter int FIFO_DATA_WIDTH    = 8,
    parameter int COMPUTE_DATA_WIDTH = 4,
    parameter int ADDRESS_SIZE       = $clog2(BUFFER_SIZE),
    parameter int NUM_SECTIONS       = BUFFER_WORD_SIZE / FIFO_DATA_WIDTH,
    parameter int SECTION_BITS       = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1,
    parameter int NUM_COMPUTE_LANES  = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH,
    parameter int MAX_BURST          = 16,
    parameter int LEN_BITS           = $clog2(MAX_BURST)
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            fifo_req_valid,
    output logic                                            fifo_req_ready,
    input  logic                                            fifo_we,
    input  logic [SECTION_BITS-1:0]                         fifo_section,
    input  logic [ADDRESS_SIZE-1:0]                         fifo_address,
    input  logic [FIFO_DATA_WIDTH-1:0]                      fifo_in,
    output logic [FIFO_DATA_WIDTH-1:0]                      fifo_out,
    output logic                                            fifo_rvalid,
    output logic                                            fifo_done,
    input  logic                                            compute_start,
    input  logic                                            compute_we,
    input  logic [ADDRESS_SIZE-1:0]                         compute_base,
    input  logic [LEN_BITS-1:0]                             compute_len,
    output logic                                            compute_busy,
    input  logic [COMPUTE_DATA_WIDTH*NUM_COMPUTE_LANES-1:0] compute_in,
    input  logic                                            compute_in_valid,
    output logic                                            compute_in_ready,
    output logic [COMPUTE_DATA_WIDTH*NUM_COMPUTE_LANES-1:0] compute_out,
    output logic                                            compute_out_valid,
    output logic                                            compute_done,
    output logic                                            compute_err
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

    localparam int                      LW        = LEN_BITS + 1;
    localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(BUFFER_SIZE - 1);
    localparam logic [ADDRESS_SIZE-1:0] ADDR_ONE  = ADDRESS_SIZE'(1);
    localparam logic [LEN_BITS:0]       FULL_LEN  = LW'(MAX_BURST);
    localparam logic [LEN_BITS:0]       LEN_ONE   = LW'(1);

    logic [BUFFER_WORD_SIZE-1:0] mem [BUFFER_SIZE];

    state_t                      state_q, state_d;
    logic [ADDRESS_SIZE-1:0]     addr_q, addr_d;
    logic [LEN_BITS:0]           len_q, len_d;
    logic [LEN_BITS:0]           cnt_q, cnt_d;
    logic                        rr_q, rr_d;
    logic [FIFO_DATA_WIDTH-1:0]  fifo_out_q;
    logic                        fifo_rvalid_q;
    logic                        fifo_done_q;
    logic [BUFFER_WORD_SIZE-1:0] compute_out_q;
    logic                        compute_out_valid_q;

    logic [LEN_BITS:0]           start_len;
    logic                        cmp_pend;
    logic                        fifo_gnt;
    logic                        cmp_gnt;
    logic                        last_beat;
    logic [ADDRESS_SIZE-1:0]     addr_inc;
    logic [BUFFER_WORD_SIZE-1:0] fifo_word;
    logic [BUFFER_WORD_SIZE-1:0] sec_mask;
    logic [BUFFER_WORD_SIZE-1:0] sec_wdata;
    logic [FIFO_DATA_WIDTH-1:0]  sec_rdata;

`ifdef UB_BOUNDS_CHECK_EN
    logic err_q, err_d;
    logic oob;
    assign oob = (32'(compute_base) + 32'(start_len)) > 32'(BUFFER_SIZE);
`endif

    assign start_len = (compute_len == '0) ? FULL_LEN : {1'b0, compute_len};
    assign last_beat = (cnt_q == len_q - LEN_ONE);
    assign addr_inc  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;

    // rr_q = 0 favours the FIFO port; the pointer only moves when both sides compete.
    assign cmp_pend = (state_q == S_RD) || ((state_q == S_WR) && compute_in_valid);
    assign fifo_gnt = rst_n && fifo_req_valid && (!cmp_pend || !rr_q);
    assign cmp_gnt  = cmp_pend && !fifo_gnt;
    assign rr_d     = (fifo_req_valid && cmp_pend) ? ~rr_q : rr_q;

    assign fifo_word = mem[fifo_address];

    // Out-of-range sections match nothing: the write mask stays empty and reads return 0.
    always_comb begin
        sec_mask  = '0;
        sec_wdata = '0;
        sec_rdata = '0;
        for (int s = 0; s < NUM_SECTIONS; s++) begin
            if (fifo_section == SECTION_BITS'(s)) begin
                sec_mask[s*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH]  = '1;
                sec_wdata[s*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH] = fifo_in;
                sec_rdata = fifo_word[s*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
`ifdef UB_BOUNDS_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (compute_start) begin
                    addr_d  = compute_base;
                    len_d   = start_len;
                    cnt_d   = '0;
                    state_d = compute_we ? S_WR : S_RD;
`ifdef UB_BOUNDS_CHECK_EN
                    err_d   = oob;
                    if (oob) state_d = S_FIN;
`endif
                end
            end
            S_RD, S_WR: begin
                if (cmp_gnt) begin
                    addr_d = addr_inc;
                    cnt_d  = cnt_q + LEN_ONE;
                    if (last_beat) state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

`ifdef UB_BOUNDS_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
`endif

    // Storage has no reset so partially written bursts survive an abort.
    always_ff @(posedge clk) begin
        if (fifo_gnt && fifo_we)
            mem[fifo_address] <= (fifo_word & ~sec_mask) | sec_wdata;
        else if (cmp_gnt && (state_q == S_WR))
            mem[addr_q] <= compute_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_out_q          <= '0;
            fifo_rvalid_q       <= 1'b0;
            fifo_done_q         <= 1'b0;
            compute_out_q       <= '0;
            compute_out_valid_q <= 1'b0;
        end else begin
            fifo_done_q         <= fifo_gnt;
            fifo_rvalid_q       <= fifo_gnt && !fifo_we;
            compute_out_valid_q <= cmp_gnt && (state_q == S_RD);
            if (fifo_gnt && !fifo_we)
                fifo_out_q <= sec_rdata;
            if (cmp_gnt && (state_q == S_RD))
                compute_out_q <= mem[addr_q];
        end
    end

    assign fifo_req_ready    = fifo_gnt;
    assign fifo_out          = fifo_out_q;
    assign fifo_rvalid       = fifo_rvalid_q;
    assign fifo_done         = fifo_done_q;
    assign compute_busy      = (state_q != S_IDLE);
    assign compute_in_ready  = (state_q == S_WR) && cmp_gnt;
    assign compute_out       = compute_out_q;
    assign compute_out_valid = compute_out_valid_q;
    assign compute_done      = (state_q == S_FIN);
`ifdef UB_BOUNDS_CHECK_EN
    assign compute_err       = (state_q == S_FIN) && err_q;
`else
    assign compute_err       = 1'b0;
`endif

endmodule

// File: tb/tb_unified_buffer_arb.sv
// Bench for unified_buffer_arb: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized mixed traffic.
module tb_unified_buffer_arb;
    localparam int BS = 1024;
    localparam int WW = 16;
    localparam int FW = 8;
    localparam int AW = 10;
    localparam int NS = 2;
    localparam int SB = 1;
    localparam int MB = 16;
    localparam int LB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_req_valid = 1'b0;
    logic          fifo_req_ready;
    logic          fifo_we = 1'b0;
    logic [SB-1:0] fifo_section = '0;
    logic [AW-1:0] fifo_address = '0;
    logic [FW-1:0] fifo_in = '0;
    logic [FW-1:0] fifo_out;
    logic          fifo_rvalid;
    logic          fifo_done;
    logic          compute_start = 1'b0;
    logic          compute_we = 1'b0;
    logic [AW-1:0] compute_base = '0;
    logic [LB-1:0] compute_len = '0;
    logic          compute_busy;
    logic [WW-1:0] compute_in = '0;
    logic          compute_in_valid = 1'b0;
    logic          compute_in_ready;
    logic [WW-1:0] compute_out;
    logic          compute_out_valid;
    logic          compute_done;
    logic          compute_err;

    always #5 clk = ~clk;

    unified_buffer_arb dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_req_valid(fifo_req_valid), .fifo_req_ready(fifo_req_ready),
        .fifo_we(fifo_we), .fifo_section(fifo_section), .fifo_address(fifo_address),
        .fifo_in(fifo_in), .fifo_out(fifo_out), .fifo_rvalid(fifo_rvalid), .fifo_done(fifo_done),
        .compute_start(compute_start), .compute_we(compute_we), .compute_base(compute_base),
        .compute_len(compute_len), .compute_busy(compute_busy),
        .compute_in(compute_in), .compute_in_valid(compute_in_valid), .compute_in_ready(compute_in_ready),
        .compute_out(compute_out), .compute_out_valid(compute_out_valid),
        .compute_done(compute_done), .compute_err(compute_err)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] patt(input int a);
        return WW'((a * 40503) ^ 23100);
    endfunction

    // Reference model: memory image, queue of burst addresses still to visit, fairness flag.
    logic [WW-1:0] m_mem [BS];
    int            m_q[$];
    bit            m_fav_cmp, m_busy, m_rd_dir, m_done, m_err;
    logic [FW-1:0] m_fifo_out;
    bit            m_rvalid, m_fdone, m_cvalid;
    logic [WW-1:0] m_cout;

    function automatic bit m_cmp_pending();
        return m_busy && !m_done && (m_q.size() > 0) && (m_rd_dir || compute_in_valid);
    endfunction

    function automatic bit m_fifo_wins();
        return rst_n && fifo_req_valid && (!m_cmp_pending() || !m_fav_cmp);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit fw, cw, both, nd, ne;
        int a, n, sec;
        if (!rst_n) begin
            m_q.delete();
            m_fav_cmp = 0; m_busy = 0; m_rd_dir = 0; m_done = 0; m_err = 0;
            m_fifo_out = '0; m_rvalid = 0; m_fdone = 0; m_cvalid = 0; m_cout = '0;
        end else begin
            fw   = m_fifo_wins();
            cw   = m_cmp_pending() && !fw;
            both = fifo_req_valid && m_cmp_pending();
            if (both) m_fav_cmp = !m_fav_cmp;
            sec = int'(fifo_section);
            m_fdone  = fw;
            m_rvalid = fw && !fifo_we;
            if (fw) begin
                if (fifo_we) begin
                    if (sec < NS) m_mem[fifo_address][sec*FW +: FW] = fifo_in;
                end else begin
                    m_fifo_out = (sec < NS) ? m_mem[fifo_address][sec*FW +: FW] : '0;
                end
            end
            m_cvalid = 0; nd = 0; ne = 0;
            if (cw) begin
                a = m_q.pop_front();
                if (m_rd_dir) begin
                    m_cout = m_mem[a];
                    m_cvalid = 1;
                end else begin
                    m_mem[a] = compute_in;
                end
                if (m_q.size() == 0) nd = 1;
            end
            if (!m_busy && compute_start) begin
                n = (compute_len == '0) ? MB : int'(compute_len);
                m_busy = 1;
                m_rd_dir = !compute_we;
`ifdef UB_BOUNDS_CHECK_EN
                if (int'(compute_base) + n > BS) begin
                    nd = 1; ne = 1; n = 0;
                end
`endif
                for (int i = 0; i < n; i++) m_q.push_back((int'(compute_base) + i) % BS);
            end else if (m_done) begin
                m_busy = 0;
            end
            m_done = nd;
            m_err  = ne;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("fifo_req_ready", fifo_req_ready, m_fifo_wins());
            check("compute_in_ready", compute_in_ready, m_cmp_pending() && !m_rd_dir && !m_fifo_wins());
            check("fifo_done", fifo_done, m_fdone);
            check("fifo_rvalid", fifo_rvalid, m_rvalid);
            check("fifo_out", fifo_out, m_fifo_out);
            check("compute_out_valid", compute_out_valid, m_cvalid);
            if (m_cvalid) check("compute_out", compute_out, m_cout);
            check("compute_busy", compute_busy, m_busy);
            check("compute_done", compute_done, m_done);
            check("compute_err", compute_err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_op(input bit we, input int sec, input int addr, input logic [FW-1:0] d,
                           output logic [FW-1:0] rd);
        int g;
        g = 0;
        fifo_req_valid = 1'b1; fifo_we = we; fifo_section = SB'(sec);
        fifo_address = AW'(addr); fifo_in = d;
        @(negedge clk);
        while (!fifo_req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("fifo_accept_timeout", 32'(g < 100), 32'd1);
        @(posedge clk);
        #1;
        fifo_req_valid = 1'b0;
        rd = fifo_out;
        check("fifo_done_pulse", fifo_done, 1'b1);
        if (!we) check("fifo_rvalid_pulse", fifo_rvalid, 1'b1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (compute_busy && g < 100) begin
            tick();
            g++;
        end
        check("idle_timeout", 32'(g < 100), 32'd1);
    endtask

    // cyc counts clock edges after the start edge until compute_done is visible.
    task automatic burst(input bit we, input int base, input int len, input logic [WW-1:0] wd[$],
                         output logic [WW-1:0] rd[$], output int cyc, output bit err);
        int  g, idx;
        bit  rdy;
        rd.delete();
        wait_idle();
        compute_start = 1'b1; compute_we = we; compute_base = AW'(base); compute_len = LB'(len);
        idx = 0;
        compute_in_valid = we;
        compute_in = (wd.size() > 0) ? wd[0] : '0;
        tick();
        compute_start = 1'b0;
        cyc = 0; g = 0;
        while (!compute_done && g < 300) begin
            @(negedge clk);
            rdy = compute_in_ready;
            @(posedge clk);
            #1;
            cyc++; g++;
            if (we && rdy) begin
                idx++;
                compute_in = (idx < wd.size()) ? wd[idx] : '0;
            end
            if (compute_out_valid) rd.push_back(compute_out);
        end
        check("burst_done_timeout", 32'(g < 300), 32'd1);
        if (!we && cyc > 0) check("done_with_last_rvalid", compute_out_valid, 1'b1);
        err = compute_err;
        compute_in_valid = 1'b0;
        compute_in = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [FW-1:0] r, lo, hi;
        logic [WW-1:0] wd[$];
        logic [WW-1:0] rd[$];
        int            cyc, g, beats;
        bit            err, rdy;

        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        check("reset_busy", compute_busy, 1'b0);
        check("reset_fifo_out", fifo_out, 8'h00);
        check("reset_done", compute_done, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fill the whole buffer with a known pattern using maximum-length (len=0) bursts.
        for (int b = 0; b < BS / MB; b++) begin
            wd.delete();
            for (int i = 0; i < MB; i++) wd.push_back(patt(b * MB + i));
            burst(1'b1, b * MB, 0, wd, rd, cyc, err);
            if (b == 0) check("len0_burst_cycles", cyc, 32'd16);
        end

        // FIFO section writes and reads.
        fifo_op(1'b1, 0, 5, 8'hAB, r);
        fifo_op(1'b1, 1, 5, 8'hCD, r);
        fifo_op(1'b0, 0, 5, 8'h00, r);
        check("fifo_read_sec0", r, 8'hAB);
        fifo_op(1'b0, 1, 5, 8'h00, r);
        check("fifo_read_sec1", r, 8'hCD);

        // Compute write then read-back burst.
        wd = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        burst(1'b1, 10, 4, wd, rd, cyc, err);
        check("wr_burst_cycles", cyc, 32'd4);
        burst(1'b0, 10, 4, wd, rd, cyc, err);
        check("rd_burst_cycles", cyc, 32'd4);
        check("rd_burst_beats", rd.size(), 32'd4);
        if (rd.size() == 4) begin
            check("rd_beat0", rd[0], 16'h1234);
            check("rd_beat1", rd[1], 16'h5678);
            check("rd_beat2", rd[2], 16'h9ABC);
            check("rd_beat3", rd[3], 16'hDEF0);
        end

        // Burst across the end of the buffer.
        wd = '{16'h1101, 16'h2202, 16'h3303, 16'h4404};
        burst(1'b1, 1022, 4, wd, rd, cyc, err);
`ifdef UB_BOUNDS_CHECK_EN
        check("oob_err", err, 1'b1);
        check("oob_no_beats", cyc, 32'd0);
        fifo_op(1'b0, 0, 1022, 8'h00, r); check("oob_keep_1022", r, patt(1022) & 16'hFF);
        fifo_op(1'b0, 0, 1023, 8'h00, r); check("oob_keep_1023", r, patt(1023) & 16'hFF);
        fifo_op(1'b0, 0, 0, 8'h00, r);    check("oob_keep_0", r, patt(0) & 16'hFF);
        fifo_op(1'b0, 1, 1, 8'h00, r);    check("oob_keep_1", r, patt(1) >> 8);
`else
        check("wrap_no_err", err, 1'b0);
        check("wrap_cycles", cyc, 32'd4);
        fifo_op(1'b0, 0, 1022, 8'h00, r); check("wrap_1022", r, 8'h01);
        fifo_op(1'b0, 0, 1023, 8'h00, r); check("wrap_1023", r, 8'h02);
        fifo_op(1'b0, 0, 0, 8'h00, r);    check("wrap_0", r, 8'h03);
        fifo_op(1'b0, 1, 1, 8'h00, r);    check("wrap_1_hi", r, 8'h44);
`endif

        // compute_start while busy must be ignored.
        wait_idle();
        compute_start = 1'b1; compute_we = 1'b0; compute_base = AW'(10); compute_len = LB'(4);
        tick();
        compute_start = 1'b0;
        tick();
        compute_start = 1'b1; compute_we = 1'b1; compute_base = AW'(300); compute_len = LB'(2);
        tick();
        compute_start = 1'b0;
        cyc = 2;
        while (!compute_done && cyc < 50) begin
            tick();
            cyc++;
        end
        check("busy_start_ignored_cycles", cyc, 32'd4);
        tick();
        check("idle_after_fin", compute_busy, 1'b0);
        tick();
        check("no_late_start", compute_busy, 1'b0);

        // Reset two beats into a length-8 write burst.
        wd.delete();
        for (int i = 0; i < 8; i++) wd.push_back(16'hB000 + WW'(i));
        wait_idle();
        compute_start = 1'b1; compute_we = 1'b1; compute_base = AW'(100); compute_len = LB'(8);
        compute_in_valid = 1'b1; compute_in = wd[0];
        tick();
        compute_start = 1'b0;
        beats = 0; g = 0;
        while (beats < 2 && g < 50) begin
            @(negedge clk);
            rdy = compute_in_ready;
            @(posedge clk);
            #1;
            g++;
            if (rdy) begin
                beats++;
                compute_in = wd[beats];
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy", compute_busy, 1'b0);
        check("rst_done", compute_done, 1'b0);
        check("rst_in_ready", compute_in_ready, 1'b0);
        check("rst_fifo_done", fifo_done, 1'b0);
        check("rst_fifo_out", fifo_out, 8'h00);
        compute_in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            fifo_op(1'b0, 0, 100 + i, 8'h00, lo);
            fifo_op(1'b0, 1, 100 + i, 8'h00, hi);
            check("rst_partial_word", {hi, lo}, (i < 2) ? (16'hB000 + 32'(i)) : 32'(patt(100 + i)));
        end

        // Contention: FIFO requests held high during a length-8 read burst.
        fifo_req_valid = 1'b1; fifo_we = 1'b0; fifo_section = '0; fifo_address = AW'(7);
        burst(1'b0, 200, 8, wd, rd, cyc, err);
        fifo_req_valid = 1'b0;
        check("contended_cycles", cyc, 32'd16);
        check("contended_beats", rd.size(), 32'd8);
        if (rd.size() == 8) begin
            check("contended_beat0", rd[0], patt(200));
            check("contended_beat7", rd[7], patt(207));
        end

        // Randomized mixed traffic around a small address window and the wrap point.
        for (int c = 0; c < 3000; c++) begin
            fifo_req_valid   = ($urandom_range(0, 2) != 0);
            fifo_we          = $urandom_range(0, 1);
            fifo_section     = SB'($urandom_range(0, NS - 1));
            fifo_address     = $urandom_range(0, 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(1008, 1023));
            fifo_in          = FW'($urandom);
            compute_start    = ($urandom_range(0, 3) == 0);
            compute_we       = $urandom_range(0, 1);
            compute_base     = $urandom_range(0, 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(1008, 1023));
            compute_len      = LB'($urandom);
            compute_in       = WW'($urandom);
            compute_in_valid = ($urandom_range(0, 3) != 0);
            tick();
        end
        fifo_req_valid = 1'b0; compute_start = 1'b0; compute_in_valid = 1'b1;
        wait_idle();
        compute_in_valid = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
